// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS I Avalon bus arbiter.
// States, requester identities and the full-word byte-enable.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUS_FETCH = 2'd1,
    BUS_DATA  = 2'd2
  } bus_state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } requester_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port
// between the instruction-fetch and load/store requesters.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_ack,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic [31:0] rdata,
  output logic        bus_timeout,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [15:0] TO_LAST =
    TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  bus_state_t  state;
  requester_t  last_grant;
  logic [15:0] stall_cnt;

  logic f_pend;
  logic d_pend;
  logic grant_f;
  logic grant_d;
  logic done;
  logic abandon;

  // a requester being acked this cycle is not re-granted yet
  assign f_pend = f_req && !f_ack;
  assign d_pend = d_req && !d_ack;

  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      unique case (1'b1)
        f_pend && d_pend: begin
          if (last_grant == REQ_DATA) grant_f = 1'b1;
          else                        grant_d = 1'b1;
        end
        f_pend && !d_pend: grant_f = 1'b1;
        !f_pend && d_pend: grant_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign done    = (state != IDLE) && !waitrequest;
  assign abandon = TO_EN && (state != IDLE) &&
                   waitrequest && (stall_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= REQ_DATA;
      stall_cnt   <= '0;
      f_ack       <= 1'b0;
      d_ack       <= 1'b0;
      rdata       <= '0;
      bus_timeout <= 1'b0;
      address     <= '0;
      read        <= 1'b0;
      write       <= 1'b0;
      writedata   <= '0;
      byteenable  <= '0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_f) begin
            address    <= f_addr;
            read       <= 1'b1;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= BE_WORD;
            last_grant <= REQ_FETCH;
            stall_cnt  <= '0;
            state      <= BUS_FETCH;
          end else if (grant_d) begin
            address    <= d_addr;
            read       <= !d_write;
            write      <= d_write;
            writedata  <= d_wdata;
            byteenable <= d_byteenable;
            last_grant <= REQ_DATA;
            stall_cnt  <= '0;
            state      <= BUS_DATA;
          end
        end
        BUS_FETCH, BUS_DATA: begin
          if (done || abandon) begin
            rdata <= (done && read) ? readdata : '0;
            read  <= 1'b0;
            write <= 1'b0;
            f_ack <= (state == BUS_FETCH);
            d_ack <= (state == BUS_DATA);
            state <= IDLE;
            if (abandon) bus_timeout <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed vector
// table, a reset-abort sequence and random traffic vs a model.
module tb_mips_bus_arbiter;

  localparam logic [31:0] FA  = 32'hBFC00000;
  localparam logic [31:0] INS = 32'h24020005;
  localparam logic [3:0]  BE  = 4'b1111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  logic        x0_fack, x0_dack, x0_to, x0_read, x0_write;
  logic [31:0] x0_rdata, x0_addr, x0_wdata;
  logic [3:0]  x0_be;
  logic        x4_fack, x4_dack, x4_to, x4_read, x4_write;
  logic [31:0] x4_rdata, x4_addr, x4_wdata;
  logic [3:0]  x4_be;

  mips_bus_arbiter u0 (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(x0_fack),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_byteenable(d_byteenable),
    .d_ack(x0_dack), .rdata(x0_rdata), .bus_timeout(x0_to),
    .address(x0_addr), .read(x0_read), .write(x0_write),
    .writedata(x0_wdata), .byteenable(x0_be),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  mips_bus_arbiter #(.TIMEOUT_CYCLES(4)) u4 (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(x4_fack),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_byteenable(d_byteenable),
    .d_ack(x4_dack), .rdata(x4_rdata), .bus_timeout(x4_to),
    .address(x4_addr), .read(x4_read), .write(x4_write),
    .writedata(x4_wdata), .byteenable(x4_be),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  typedef struct {
    logic        read, write, fack, dack, to;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
  } obs_t;

  typedef struct {
    string       n;
    logic        rst, fr, dr, dw, wq;
    logic [31:0] fa, da, dd, rq;
    logic [3:0]  dbe;
    bit          sel;
    obs_t        e;
  } vec_t;

  // owner/last: 0 none, 1 fetch, 2 data
  typedef struct {
    int   owner;
    int   last;
    int   stalls;
    obs_t o;
  } mdl_t;

  int nchk = 0;
  int nfail = 0;
  vec_t tbl[$];

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", n, got, want);
    end
  endtask

  function automatic obs_t sample(input bit sel);
    obs_t o;
    if (sel) begin
      o.read = x4_read; o.write = x4_write;
      o.fack = x4_fack; o.dack = x4_dack; o.to = x4_to;
      o.addr = x4_addr; o.wdata = x4_wdata;
      o.rdata = x4_rdata; o.be = x4_be;
    end else begin
      o.read = x0_read; o.write = x0_write;
      o.fack = x0_fack; o.dack = x0_dack; o.to = x0_to;
      o.addr = x0_addr; o.wdata = x0_wdata;
      o.rdata = x0_rdata; o.be = x0_be;
    end
    return o;
  endfunction

  task automatic cmp(input string n, input obs_t g,
                     input obs_t e, input bit all);
    chk({n, ".read"},  32'(g.read),  32'(e.read));
    chk({n, ".write"}, 32'(g.write), 32'(e.write));
    chk({n, ".fack"},  32'(g.fack),  32'(e.fack));
    chk({n, ".dack"},  32'(g.dack),  32'(e.dack));
    chk({n, ".tmo"},   32'(g.to),    32'(e.to));
    chk({n, ".excl"},  32'(g.read & g.write), 32'd0);
    if (all || e.read || e.write) begin
      chk({n, ".addr"},  g.addr,      e.addr);
      chk({n, ".wdata"}, g.wdata,     e.wdata);
      chk({n, ".be"},    32'(g.be),   32'(e.be));
    end
    if (all || e.fack || e.dack)
      chk({n, ".rdata"}, g.rdata, e.rdata);
  endtask

  task automatic add(
    input string n, input logic rst, fr, input logic [31:0] fa,
    input logic dr, dw, input logic [31:0] da, dd,
    input logic [3:0] dbe, input logic wq, input logic [31:0] rq,
    input bit sel, input logic er, ew, input logic [31:0] ea, ed,
    input logic [3:0] eb, input logic fk, dk,
    input logic [31:0] erd, input logic eto);
    vec_t v;
    v.n = n; v.rst = rst; v.fr = fr; v.fa = fa;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.dbe = dbe;
    v.wq = wq; v.rq = rq; v.sel = sel;
    v.e.read = er; v.e.write = ew; v.e.addr = ea;
    v.e.wdata = ed; v.e.be = eb; v.e.fack = fk; v.e.dack = dk;
    v.e.rdata = erd; v.e.to = eto;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; f_req = v.fr; f_addr = v.fa;
    d_req = v.dr; d_write = v.dw; d_addr = v.da;
    d_wdata = v.dd; d_byteenable = v.dbe;
    waitrequest = v.wq; readdata = v.rq;
  endtask

  task automatic idle_inputs();
    f_req = 0; f_addr = 0; d_req = 0; d_write = 0;
    d_addr = 0; d_wdata = 0; d_byteenable = 0;
    waitrequest = 0; readdata = 0;
  endtask

  function automatic mdl_t mdl_init();
    mdl_t m;
    m.owner = 0; m.last = 2; m.stalls = 0;
    m.o = '{default: '0};
    return m;
  endfunction

  // one clock edge of the arbiter, from the current inputs
  function automatic mdl_t step(input mdl_t m, input int lim);
    mdl_t n;
    bit   fm, dm;
    int   pick;
    n = m;
    n.o.fack = 0;
    n.o.dack = 0;
    if (m.owner == 0) begin
      fm = f_req && !m.o.fack;
      dm = d_req && !m.o.dack;
      pick = 0;
      if (fm && dm) pick = (m.last == 2) ? 1 : 2;
      else if (fm)  pick = 1;
      else if (dm)  pick = 2;
      if (pick == 1) begin
        n.o.read = 1; n.o.write = 0; n.o.addr = f_addr;
        n.o.wdata = 0; n.o.be = 4'hF;
      end else if (pick == 2) begin
        n.o.read = !d_write; n.o.write = d_write;
        n.o.addr = d_addr; n.o.wdata = d_wdata;
        n.o.be = d_byteenable;
      end
      if (pick != 0) begin
        n.owner = pick; n.last = pick; n.stalls = 0;
      end
    end else if (!waitrequest || (lim > 0 && m.stalls + 1 >= lim)) begin
      n.o.rdata = (!waitrequest && !m.o.write) ? readdata : 32'd0;
      if (waitrequest) n.o.to = 1;
      n.o.read = 0; n.o.write = 0;
      n.o.fack = (m.owner == 1);
      n.o.dack = (m.owner == 2);
      n.owner = 0;
    end else begin
      n.stalls = m.stalls + 1;
    end
    return n;
  endfunction

  mdl_t m0, m4;
  int   run;

  initial begin
    reset = 0;
    idle_inputs();

    for (int i = 0; i < 3; i++)
      add($sformatf("rst%0d", i), 0, 1, FA, 0, 0, 0, 0, 0, 0, INS, 0,
          0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("f_grant", 1, 1, FA, 0, 0, 0, 0, 0, 0, INS, 0,
        1, 0, FA, 0, BE, 0, 0, 0, 0);
    add("f_done", 1, 1, FA, 0, 0, 0, 0, 0, 0, INS, 0,
        0, 0, 0, 0, 0, 1, 0, INS, 0);
    add("f_idle", 1, 0, FA, 0, 0, 0, 0, 0, 0, INS, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0);

    add("st_grant", 1, 0, 0, 1, 1, 32'h1000, 32'hDEADBEEF, 4'b0011,
        1, 32'h55555555, 0,
        0, 1, 32'h1000, 32'hDEADBEEF, 4'b0011, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++)
      add($sformatf("st_stall%0d", i), 1, 0, 0, 1, 1, 32'h1000,
          32'hDEADBEEF, 4'b0011, 1, 32'h55555555, 0,
          0, 1, 32'h1000, 32'hDEADBEEF, 4'b0011, 0, 0, 0, 0);
    add("st_done", 1, 0, 0, 1, 1, 32'h1000, 32'hDEADBEEF, 4'b0011,
        0, 32'h55555555, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add("st_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("rst_a", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0);

    add("c_f1g", 1, 1, 32'h400000, 1, 0, 32'h10010000, 0, BE, 0,
        32'h11111111, 0, 1, 0, 32'h400000, 0, BE, 0, 0, 0, 0);
    add("c_f1d", 1, 1, 32'h400000, 1, 0, 32'h10010000, 0, BE, 0,
        32'h11111111, 0, 0, 0, 0, 0, 0, 1, 0, 32'h11111111, 0);
    add("c_d1g", 1, 1, 32'h400000, 1, 0, 32'h10010000, 0, BE, 0,
        32'h22222222, 0, 1, 0, 32'h10010000, 0, BE, 0, 0, 0, 0);
    add("c_d1d", 1, 1, 32'h400000, 1, 0, 32'h10010000, 0, BE, 0,
        32'h22222222, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222, 0);
    add("c_f2g", 1, 1, 32'h400000, 1, 0, 32'h10010000, 0, BE, 0,
        32'h11111111, 0, 1, 0, 32'h400000, 0, BE, 0, 0, 0, 0);
    add("c_f2d", 1, 1, 32'h400000, 1, 0, 32'h10010000, 0, BE, 0,
        32'h11111111, 0, 0, 0, 0, 0, 0, 1, 0, 32'h11111111, 0);
    add("c_d2g", 1, 0, 32'h400000, 1, 0, 32'h10010000, 0, BE, 0,
        32'h22222222, 0, 1, 0, 32'h10010000, 0, BE, 0, 0, 0, 0);
    add("c_d2d", 1, 0, 32'h400000, 1, 0, 32'h10010000, 0, BE, 0,
        32'h22222222, 0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222, 0);
    add("c_end", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0);

    add("p_g", 1, 1, 32'h400010, 0, 0, 0, 0, 0, 1, 0, 0,
        1, 0, 32'h400010, 0, BE, 0, 0, 0, 0);
    for (int i = 1; i <= 2; i++)
      add($sformatf("p_s%0d", i), 1, 1, 32'h400010, 1, 0,
          32'h10010040, 0, 4'b0100, 1, 0, 0,
          1, 0, 32'h400010, 0, BE, 0, 0, 0, 0);
    add("p_f", 1, 1, 32'h400010, 1, 0, 32'h10010040, 0, 4'b0100,
        0, 32'h33333333, 0, 0, 0, 0, 0, 0, 1, 0, 32'h33333333, 0);
    add("p_dg", 1, 0, 32'h400010, 1, 0, 32'h10010040, 0, 4'b0100,
        0, 32'h33333333, 0, 1, 0, 32'h10010040, 0, 4'b0100,
        0, 0, 0, 0);
    add("p_dd", 1, 0, 0, 1, 0, 32'h10010040, 0, 4'b0100,
        0, 32'h44444444, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44444444, 0);
    add("p_end", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0);

    add("t_g", 1, 1, 32'h400020, 0, 0, 0, 0, 0, 1, 32'hABCD0123, 1,
        1, 0, 32'h400020, 0, BE, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++)
      add($sformatf("t_s%0d", i), 1, 1, 32'h400020, 0, 0, 0, 0, 0,
          1, 32'hABCD0123, 1, 1, 0, 32'h400020, 0, BE, 0, 0, 0, 0);
    add("t_ab", 1, 1, 32'h400020, 0, 0, 0, 0, 0, 1, 32'hABCD0123, 1,
        0, 0, 0, 0, 0, 1, 0, 0, 1);
    add("t_hold", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,
        0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("t_hold2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
        0, 0, 0, 0, 0, 0, 0, 0, 1);
    add("t_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
        0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("rst_b", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      @(posedge clk);
      #1;
      cmp(tbl[i].n, sample(tbl[i].sel), tbl[i].e, !tbl[i].rst);
    end

    // reset during the second stall cycle of a load
    @(negedge clk);
    idle_inputs();
    reset = 1; d_req = 1; d_addr = 32'h2000;
    d_byteenable = BE; waitrequest = 1;
    @(posedge clk); #1;
    chk("ml.grant", 32'(x0_read), 32'd1);
    @(posedge clk); #1;
    chk("ml.stall", 32'(x0_read), 32'd1);
    #2 reset = 0;
    #1;
    chk("ml.async_read", 32'(x0_read), 32'd0);
    chk("ml.async_addr", x0_addr, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("ml.noack", 32'(x0_dack), 32'd0);
    end
    @(negedge clk);
    reset = 1; d_req = 0;
    @(posedge clk); #1;
    chk("ml.rel_read", 32'(x0_read), 32'd0);
    chk("ml.rel_dack", 32'(x0_dack), 32'd0);
    @(negedge clk);
    f_req = 1; f_addr = FA; waitrequest = 0; readdata = INS;
    @(posedge clk); #1;
    chk("ml.idle_read", 32'(x0_read), 32'd1);
    chk("ml.idle_addr", x0_addr, FA);
    @(posedge clk); #1;
    chk("ml.fack", 32'(x0_fack), 32'd1);
    chk("ml.rdata", x0_rdata, INS);

    // random traffic against the reference model
    @(negedge clk);
    reset = 0;
    idle_inputs();
    @(negedge clk);
    reset = 1;
    m0 = mdl_init();
    m4 = mdl_init();
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      cmp($sformatf("rnd%0d.t0", c), sample(0), m0.o, 0);
      cmp($sformatf("rnd%0d.t4", c), sample(1), m4.o, 0);
      if (f_req) begin
        if (m0.o.fack) begin
          f_req = 1'($urandom_range(1));
          f_addr = $urandom & 32'hFFFFFFFC;
        end
      end else if ($urandom_range(2) == 0) begin
        f_req = 1;
        f_addr = $urandom & 32'hFFFFFFFC;
      end
      if (!d_req || m0.o.dack) begin
        d_req = (d_req && m0.o.dack) ? 1'($urandom_range(1))
                                     : ($urandom_range(2) == 0);
        d_write = 1'($urandom_range(1));
        d_addr = $urandom;
        d_wdata = $urandom;
        d_byteenable = 4'($urandom_range(15));
      end
      waitrequest = (run >= 3) ? 1'b0 : ($urandom_range(9) < 4);
      run = waitrequest ? run + 1 : 0;
      readdata = $urandom;
      m0 = step(m0, 0);
      m4 = step(m4, 4);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
